// File: rtl/crank_cam_gen.sv
// Crank/cam trigger-pattern generator: a TEETH-MISSING toothed-wheel square wave plus a cam signal once per two revolutions.
// Optional macro CRANK_CAM_GEN_RAMP_EN: active period slews one clock per slot toward the requested period.
module crank_cam_gen #(
  parameter int TEETH       = 60,
  parameter int MISSING     = 2,
  parameter int PERIOD_W    = 24,
  parameter int START_TOOTH = 53,
  parameter int CAM_RISE    = 4,
  parameter int CAM_FALL    = 54
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [PERIOD_W-1:0]      period,
  input  logic                     period_wr,
  output logic                     vr,
  output logic                     cam,
  output logic [$clog2(TEETH)-1:0] tooth,
  output logic                     cam_phase,
  output logic                     rev_pulse
);

  localparam int TW = $clog2(TEETH);
  localparam int CW = PERIOD_W + $clog2(MISSING + 2);
  localparam logic [TW-1:0]       LAST_TOOTH   = TW'(TEETH - MISSING - 1);
  localparam logic [TW-1:0]       HALF_TOOTH   = TW'(TEETH / 2);
  localparam logic [TW-1:0]       RISE_TOOTH   = TW'(CAM_RISE);
  localparam logic [TW-1:0]       FALL_TOOTH   = TW'(CAM_FALL);
  localparam logic [TW-1:0]       RESET_TOOTH  = TW'(START_TOOTH);
  localparam logic [PERIOD_W-1:0] MIN_PERIOD   = PERIOD_W'(2);
  localparam logic [PERIOD_W-1:0] RESET_PERIOD = PERIOD_W'(4);

  logic [PERIOD_W-1:0] shadow;
  logic [PERIOD_W-1:0] active;
  logic [PERIOD_W-1:0] next_period;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       p_ext;
  logic [CW-1:0]       slot_len;
  logic [CW-1:0]       vr_start;
  logic [TW-1:0]       next_tooth;
  logic                boundary;

  // The gap slot absorbs the missing teeth; vr is high for the last ceil(P/2) clocks of any slot.
  always_comb begin
    p_ext      = CW'(active);
    slot_len   = (tooth == LAST_TOOTH) ? p_ext * CW'(MISSING + 1) : p_ext;
    vr_start   = slot_len - (p_ext - (p_ext >> 1));
    boundary   = (cnt == slot_len - CW'(1));
    next_tooth = (tooth == LAST_TOOTH) ? '0 : tooth + TW'(1);
`ifdef CRANK_CAM_GEN_RAMP_EN
    if (active < shadow)
      next_period = active + PERIOD_W'(1);
    else if (active > shadow)
      next_period = active - PERIOD_W'(1);
    else
      next_period = shadow;
`else
    next_period = shadow;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow    <= RESET_PERIOD;
      active    <= RESET_PERIOD;
      cnt       <= '0;
      tooth     <= RESET_TOOTH;
      vr        <= 1'b0;
      cam       <= 1'b1;
      cam_phase <= 1'b0;
      rev_pulse <= 1'b0;
    end else begin
      rev_pulse <= 1'b0;
      if (period_wr)
        shadow <= (period < MIN_PERIOD) ? MIN_PERIOD : period;
      if (en) begin
        if (boundary) begin
          cnt       <= '0;
          tooth     <= next_tooth;
          active    <= next_period;
          vr        <= 1'b0;
          rev_pulse <= (next_tooth == '0);
          if (next_tooth == HALF_TOOTH)
            cam_phase <= ~cam_phase;
          // Cam edges use the parity in force before this boundary.
          if (cam_phase) begin
            if (next_tooth == FALL_TOOTH)
              cam <= 1'b0;
            else if (next_tooth == RISE_TOOTH)
              cam <= 1'b1;
          end
        end else begin
          cnt <= cnt + CW'(1);
          vr  <= ((cnt + CW'(1)) >= vr_start);
        end
      end
    end
  end

endmodule

// File: tb/tb_crank_cam_gen.sv
// Self-checking bench for crank_cam_gen: slot-level behavioural model, directed literal checks, randomized run.
// Honours CRANK_CAM_GEN_RAMP_EN when the design is built with it.
module tb_crank_cam_gen;

  localparam int TEETH       = 60;
  localparam int MISSING     = 2;
  localparam int PERIOD_W    = 24;
  localparam int START_TOOTH = 53;
  localparam int CAM_RISE    = 4;
  localparam int CAM_FALL    = 54;
  localparam int NSLOTS      = TEETH - MISSING;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                en = 1'b0;
  logic                period_wr = 1'b0;
  logic [PERIOD_W-1:0] period = '0;
  logic                vr;
  logic                cam;
  logic [5:0]          tooth;
  logic                cam_phase;
  logic                rev_pulse;

  int total = 0;
  int bad = 0;
  bit check_en = 1'b0;

  crank_cam_gen #(
    .TEETH(TEETH), .MISSING(MISSING), .PERIOD_W(PERIOD_W),
    .START_TOOTH(START_TOOTH), .CAM_RISE(CAM_RISE), .CAM_FALL(CAM_FALL)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .period(period), .period_wr(period_wr),
    .vr(vr), .cam(cam), .tooth(tooth), .cam_phase(cam_phase), .rev_pulse(rev_pulse)
  );

  always #5 clk = ~clk;

  // Reference model: position within the current slot plus the wheel/cam bookkeeping.
  int m_pos, m_p, m_shadow, m_tooth, m_phase, m_cam, m_rev;

  function automatic int slotLen(input int t, input int p);
    return (t == NSLOTS - 1) ? (MISSING + 1) * p : p;
  endfunction

  function automatic int expVr();
    return (m_pos >= slotLen(m_tooth, m_p) - (m_p + 1) / 2) ? 1 : 0;
  endfunction

  initial begin
    m_pos = 0; m_p = 4; m_shadow = 4; m_tooth = START_TOOTH;
    m_phase = 0; m_cam = 1; m_rev = 0;
    forever begin : model_step
      int new_shadow;
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_pos = 0; m_p = 4; m_shadow = 4; m_tooth = START_TOOTH;
        m_phase = 0; m_cam = 1; m_rev = 0;
      end else begin
        new_shadow = period_wr ? ((int'(period) < 2) ? 2 : int'(period)) : m_shadow;
        m_rev = 0;
        if (en) begin
          if (m_pos == slotLen(m_tooth, m_p) - 1) begin
            m_pos = 0;
            m_tooth = (m_tooth + 1) % NSLOTS;
`ifdef CRANK_CAM_GEN_RAMP_EN
            if (m_p < m_shadow) m_p++;
            else if (m_p > m_shadow) m_p--;
`else
            m_p = m_shadow;
`endif
            m_rev = (m_tooth == 0) ? 1 : 0;
            if (m_phase == 1 && m_tooth == CAM_FALL) m_cam = 0;
            if (m_phase == 1 && m_tooth == CAM_RISE) m_cam = 1;
            if (m_tooth == TEETH / 2) m_phase = 1 - m_phase;
          end else begin
            m_pos++;
          end
        end
        m_shadow = new_shadow;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic w, input int p);
    en = e;
    period_wr = w;
    period = p[PERIOD_W-1:0];
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (check_en) begin
        checkOutput("vr", int'(vr), expVr());
        checkOutput("cam", int'(cam), m_cam);
        checkOutput("tooth", int'(tooth), m_tooth);
        checkOutput("cam_phase", int'(cam_phase), m_phase);
        checkOutput("rev_pulse", int'(rev_pulse), m_rev);
      end
    end
  end

  task automatic writePeriod(input int p);
    @(negedge clk);
    applyStimulus(en, 1'b1, p);
    @(negedge clk);
    period_wr = 1'b0;
  endtask

  task automatic waitTooth(input int t);
    int n = 0;
    while (int'(tooth) != t && n < 8000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wait_tooth", int'(tooth), t);
  endtask

  // Call on the first negedge of a slot; returns on the first negedge of the next slot.
  task automatic measureSlot(input int wr_at, input int wr_val, output int len, output int hi);
    int t0;
    t0 = int'(tooth);
    len = 0;
    hi = 0;
    do begin
      if (len == wr_at) begin
        period_wr = 1'b1;
        period = wr_val[PERIOD_W-1:0];
      end else begin
        period_wr = 1'b0;
      end
      hi += int'(vr);
      len++;
      @(negedge clk);
    end while (int'(tooth) == t0 && len < 2000);
    period_wr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int len, hi, saved_tooth, saved_vr, saved_cam, saved_phase, rev_seen;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    check_en = 1'b1;
    @(negedge clk);
    checkOutput("reset_vr", int'(vr), 0);
    checkOutput("reset_cam", int'(cam), 1);
    checkOutput("reset_tooth", int'(tooth), 53);
    checkOutput("reset_cam_phase", int'(cam_phase), 0);
    checkOutput("reset_rev_pulse", int'(rev_pulse), 0);

`ifndef CRANK_CAM_GEN_RAMP_EN
    applyStimulus(1'b1, 1'b1, 64);
    len = 0;
    do begin
      @(negedge clk);
      period_wr = 1'b0;
      len++;
    end while (int'(tooth) == 53 && len < 100);
    checkOutput("first_slot_len", len, 4);
    checkOutput("tooth_after_first", int'(tooth), 54);
    for (int t = 54; t <= 56; t++) begin
      measureSlot(-1, 0, len, hi);
      checkOutput("slot_len_64", len, 64);
      checkOutput("slot_hi_64", hi, 32);
    end
    checkOutput("tooth_gap", int'(tooth), 57);
    measureSlot(-1, 0, len, hi);
    checkOutput("gap_len", len, 192);
    checkOutput("gap_hi", hi, 32);
    checkOutput("wrap_tooth", int'(tooth), 0);
    checkOutput("wrap_rev_pulse", int'(rev_pulse), 1);

    measureSlot(10, 100, len, hi);
    checkOutput("slot_before_change", len, 64);
    measureSlot(-1, 0, len, hi);
    checkOutput("slot_len_100", len, 100);
    checkOutput("slot_hi_100", hi, 50);
    measureSlot(5, 1, len, hi);
    checkOutput("slot_len_100b", len, 100);
    measureSlot(-1, 0, len, hi);
    checkOutput("slot_len_clamped", len, 2);
    checkOutput("slot_hi_clamped", hi, 1);
    measureSlot(1, 64, len, hi);
    checkOutput("slot_len_wr_at_boundary", len, 2);
    measureSlot(-1, 0, len, hi);
    checkOutput("slot_len_deferred", len, 2);
    measureSlot(-1, 0, len, hi);
    checkOutput("slot_len_back_to_64", len, 64);
`else
    applyStimulus(1'b1, 1'b1, 9);
    len = 0;
    do begin
      @(negedge clk);
      period_wr = 1'b0;
      len++;
    end while (int'(tooth) == 53 && len < 100);
    checkOutput("ramp_first_slot", len, 4);
    measureSlot(-1, 0, len, hi);
    checkOutput("ramp_slot_5", len, 5);
    measureSlot(-1, 0, len, hi);
    checkOutput("ramp_slot_6", len, 6);
    measureSlot(-1, 0, len, hi);
    checkOutput("ramp_slot_7", len, 7);
    measureSlot(-1, 0, len, hi);
    checkOutput("ramp_gap_8", len, 24);
    measureSlot(-1, 0, len, hi);
    checkOutput("ramp_slot_9", len, 9);
    measureSlot(-1, 0, len, hi);
    checkOutput("ramp_slot_9_hold", len, 9);
`endif

    // Cam: first entry to the half-wheel tooth since reset starts the cam-active revolution.
    writePeriod(2);
    waitTooth(30);
    checkOutput("cam_phase_first", int'(cam_phase), 1);
    checkOutput("cam_high_at_30", int'(cam), 1);
    waitTooth(54);
    checkOutput("cam_low_at_54", int'(cam), 0);
    waitTooth(4);
    checkOutput("cam_high_at_4", int'(cam), 1);
    waitTooth(30);
    checkOutput("cam_phase_second", int'(cam_phase), 0);
    waitTooth(54);
    checkOutput("cam_held_at_54", int'(cam), 1);

`ifndef CRANK_CAM_GEN_RAMP_EN
    writePeriod(64);
    waitTooth(10);
    repeat (40) @(negedge clk);
    en = 1'b0;
    saved_tooth = int'(tooth);
    saved_vr = int'(vr);
    saved_cam = int'(cam);
    saved_phase = int'(cam_phase);
    rev_seen = 0;
    repeat (500) begin
      @(negedge clk);
      if (rev_pulse) rev_seen = 1;
    end
    checkOutput("hold_tooth", int'(tooth), 10);
    checkOutput("hold_vr", int'(vr), 1);
    checkOutput("hold_tooth_same", int'(tooth), saved_tooth);
    checkOutput("hold_vr_same", int'(vr), saved_vr);
    checkOutput("hold_cam_same", int'(cam), saved_cam);
    checkOutput("hold_phase_same", int'(cam_phase), saved_phase);
    checkOutput("hold_no_rev_pulse", rev_seen, 0);
    en = 1'b1;
    len = 0;
    do begin
      @(negedge clk);
      len++;
    end while (int'(tooth) == 10 && len < 200);
    checkOutput("resume_remaining", len, 24);

    waitTooth(57);
    repeat (170) @(negedge clk);
    checkOutput("pre_reset_vr", int'(vr), 1);
    checkOutput("pre_reset_cam", int'(cam), 0);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_reset_vr", int'(vr), 0);
    checkOutput("async_reset_cam", int'(cam), 1);
    checkOutput("async_reset_tooth", int'(tooth), 53);
    checkOutput("async_reset_phase", int'(cam_phase), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
`endif

    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      applyStimulus(($urandom_range(0, 99) < 95), ($urandom_range(0, 99) < 2), $urandom_range(0, 24));
    end
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 0);
    @(negedge clk);
    check_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
